// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src to dst over a single-port SRAM, two cycles per word.
// Optional running checksum of copied words is enabled by defining MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
  parameter int AW   = 14,
  parameter int DW   = 32,
  parameter int LENW = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   src,
  input  logic [AW-1:0]   dst,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [LENW-1:0] words_done,
  output logic [DW-1:0]   checksum,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0]   src_r, dst_r;
  logic [LENW-1:0] len_r;
  logic [DW-1:0]   data_r;
  logic            last;
  // words_done doubles as the word index of the transfer in progress
  assign last = (words_done + 1'b1) == len_r;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((len == '0) ? DONE : READ) : IDLE;
      READ:    state_nx = abort ? DONE : WRITE;
      WRITE:   state_nx = (abort || last) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      src_r      <= '0;
      dst_r      <= '0;
      len_r      <= '0;
      data_r     <= '0;
      words_done <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        src_r      <= src;
        dst_r      <= dst;
        len_r      <= len;
        words_done <= '0;
      end
      if (state == READ) data_r <= mem_rd;
      if (state == WRITE) words_done <= words_done + 1'b1;
    end
  end
`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (state == READ && !abort) checksum <= checksum + mem_rd;
  end
`else
  assign checksum = '0;
`endif
  assign busy     = (state == READ) || (state == WRITE);
  assign done     = state == DONE;
  assign mem_we   = state == WRITE;
  assign mem_wd   = data_r;
  assign mem_addr = (state == READ)  ? src_r + words_done[AW-1:0] :
                    (state == WRITE) ? dst_r + words_done[AW-1:0] : '0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: table-driven transfers plus abort/reset/restart sequences against an SRAM model,
// with a write scoreboard fed by the expected destination writes.
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [13:0] src = '0, dst = '0;
  logic [14:0] len = '0;
  logic        busy, done, mem_we;
  logic [14:0] words_done;
  logic [31:0] checksum, mem_wd, mem_rd;
  logic [13:0] mem_addr;

  mem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .words_done(words_done), .checksum(checksum),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16384];
  logic        pl_we = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_d = '0;
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    if (pl_we) mem[pl_addr] <= pl_d;
  end

  typedef struct {logic [13:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  int n_chk = 0, n_pass = 0;

  always @(negedge clk) begin
    if (reset && mem_we) begin
      n_chk++;
      if (q.size() == 0) $display("FAIL sb_unexpected_write: got addr %h data %h want no write", mem_addr, mem_wd);
      else begin
        wr_t e;
        e = q.pop_front();
        if (mem_addr === e.a && mem_wd === e.d) n_pass++;
        else $display("FAIL sb_write: got addr %h data %h want addr %h data %h", mem_addr, mem_wd, e.a, e.d);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] cs(input logic [31:0] s);
`ifdef MEM_COPY_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  task automatic poke(input logic [13:0] a, input logic [31:0] v);
    pl_addr = a; pl_d = v; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic launch(input logic [13:0] s, input logic [13:0] d, input logic [14:0] l);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 40000) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Preload source words seed+step*k, queue the expected writes, return their sum.
  task automatic setup(input logic [13:0] s, input logic [13:0] d, input int n, input int nexp,
                       input logic [31:0] seed, input logic [31:0] step, output logic [31:0] sum);
    sum = '0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] v;
      v = seed + step * k;
      poke(s + 14'(k), v);
      if (k < nexp) begin
        q.push_back('{d + 14'(k), v});
        sum += v;
      end
    end
    poke(d + 14'(nexp), 32'hCAFEF00D);
  endtask

  typedef struct {logic [13:0] s, d; logic [14:0] l; logic [31:0] seed, step;} row_t;
  row_t rows[5];

  task automatic run_row(input row_t r);
    logic [31:0] sum;
    int c;
    setup(r.s, r.d, int'(r.l), int'(r.l), r.seed, r.step, sum);
    launch(r.s, r.d, r.l);
    chk("busy_after_start", busy, r.l != 0);
    wait_done(1, c);
    chk("latency", c, 2 * int'(r.l) + 1);
    chk("busy_at_done", busy, 0);
    chk("words_done", words_done, r.l);
    chk("checksum", checksum, cs(sum));
    chk("sb_empty", q.size(), 0);
    chk("sentinel", mem[r.d + r.l[13:0]], 32'hCAFEF00D);
    for (int k = 0; k < int'(r.l); k++) chk("dst_word", mem[r.d + 14'(k)], r.seed + r.step * k);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("words_hold", words_done, r.l);
  endtask

  initial begin
    logic [31:0] sum;
    int c;
    rows[0] = '{14'd0,     14'd100,   15'd4, 32'd1,          32'd1};
    rows[1] = '{14'd0,     14'd300,   15'd0, 32'd0,          32'd0};
    rows[2] = '{14'd500,   14'd600,   15'd5, 32'hA5A50000,   32'd7};
    rows[3] = '{14'd16380, 14'd10,    15'd6, 32'h12345678,   32'h01010101};
    rows[4] = '{14'd1000,  14'd16382, 15'd4, 32'hFFFFFFF0,   32'h00000009};

    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_done, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wd", mem_wd, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_row(rows[i]);

    // source address wrap 16383 -> 0
    poke(14'd16383, 32'hDEADBEEF);
    poke(14'd0, 32'h00001234);
    q.push_back('{14'd200, 32'hDEADBEEF});
    q.push_back('{14'd201, 32'h00001234});
    launch(14'd16383, 14'd200, 15'd2);
    wait_done(1, c);
    chk("wrap_latency", c, 5);
    chk("wrap_dst0", mem[200], 32'hDEADBEEF);
    chk("wrap_dst1", mem[201], 32'h00001234);
    chk("wrap_checksum", checksum, cs(32'hDEADBEEF + 32'h1234));
    @(negedge clk);

    // abort during the third WRITE cycle
    setup(14'd2000, 14'd3000, 8, 3, 32'h00C0FFEE, 32'd3, sum);
    launch(14'd2000, 14'd3000, 15'd8);
    repeat (5) @(negedge clk);
    chk("abort_in_write", mem_we, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_words", words_done, 3);
    chk("abort_sentinel", mem[3003], 32'hCAFEF00D);
    chk("abort_sb_empty", q.size(), 0);
    @(negedge clk);
    chk("abort_done_drop", done, 0);

    // async reset in the middle of the third WRITE
    setup(14'd4000, 14'd5000, 8, 2, 32'h0BADF00D, 32'd11, sum);
    launch(14'd4000, 14'd5000, 15'd8);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_we", mem_we, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_words", words_done, 0);
    chk("rstmid_checksum", checksum, 0);
    @(negedge clk);
    reset = 1'b1;
    chk("rstmid_sentinel", mem[5002], 32'hCAFEF00D);
    chk("rstmid_dst1", mem[5001], 32'h0BADF00D + 32'd11);
    chk("rstmid_sb_empty", q.size(), 0);
    @(negedge clk);
    run_row(rows[2]);

    // start while busy must be ignored
    setup(14'd6000, 14'd7000, 3, 3, 32'h77770000, 32'd5, sum);
    poke(14'd7500, 32'hCAFEF00D);
    launch(14'd6000, 14'd7000, 15'd3);
    src = 14'd6500; dst = 14'd7500; len = 15'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, c);
    chk("busy_start_latency", c, 7);
    chk("busy_start_words", words_done, 3);
    chk("busy_start_checksum", checksum, cs(sum));
    chk("busy_start_untouched", mem[7500], 32'hCAFEF00D);
    chk("busy_start_sb_empty", q.size(), 0);
    @(negedge clk);
    chk("busy_start_idle", busy | done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
